fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit core. It sits upstream of decode and the register file, and owns the program counter. It issues reads to instruction memory over a request/grant port, so it can share a memory with the data path. Fetched bytes are buffered, tagged with their PC, in a small prefetch FIFO. Decode receives them over a valid/ready handshake. A redirect input supports jumps and branches.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDataW = 8;
  localparam logic [7:0]  DefaultResetPc = 8'h00;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: holds fetched instructions tagged with their PC until decode takes them.
// Flush wins over push; storage is cleared on reset so the head reads zero out of reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign do_push = push && (count_q != CntW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-outstanding reads over req/gnt, buffers
// responses in a prefetch FIFO and hands them to decode over valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic [CntW-1:0]   count;
  logic [CntW:0]     occupancy;
  logic              grant, resp_push, pop;

  // FIFO credit includes the response still in flight; a same-cycle pop is not credited
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, inflight_q};
  assign grant     = imem_req && imem_gnt;
  assign resp_push = inflight_q && !squash_q && !redirect_valid;
  assign pop       = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StBoot;
    else      state_q <= state_d;
  end

  // Next-state logic; a halt only lands once no response is outstanding
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (halt && !inflight_q) state_d = StHalted;
      StHalted: if (!halt) state_d = StRun;
      default:  state_d = StBoot;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req = (state_q == StRun) && !halt && !redirect_valid
               && (occupancy < (CntW + 1)'(DEPTH));
    halted   = (state_q == StHalted);
  end

  // PC, in-flight tracking and squash next-state
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = grant;
    squash_d      = squash_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    if (grant) begin
      inflight_pc_d = fetch_pc_q;
      // Requests are already gated by redirect, so this only guards the rule itself
      squash_d      = redirect_valid;
    end
  end

  // PC and in-flight registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count != '0);

  fetch_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (resp_push),
    .push_data({inflight_pc_q, imem_rdata}),
    .pop      (pop),
    .flush    (redirect_valid),
    .head_data({instr_pc, instr_data}),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based reference of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic              clk, rst;
  logic              imem_req, imem_gnt;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid, instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt, halted;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: returns addr ^ A5 one cycle after a grant, noise otherwise
  logic       resp_pend;
  logic [7:0] resp_addr, junk;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_pend <= 1'b0;
    end else begin
      resp_pend <= imem_req & imem_gnt;
      resp_addr <= imem_addr;
      junk      <= 8'($urandom);
    end
  end
  assign imem_rdata = resp_pend ? (resp_addr ^ 8'hA5) : junk;

  // Reference: 0 = boot, 1 = run, 2 = halted; queue holds {pc, data}
  int          m_state;
  logic [7:0]  m_pc, m_ipc;
  bit          m_infl;
  logic [15:0] m_q[$];
  int          cyc;

  // Observations of the most recent cycle
  int         o_cyc;
  bit         o_req, o_gnt, o_valid, o_pop, o_halted;
  logic [7:0] o_addr, o_pc, o_data;

  task automatic model_reset();
    m_state = 0;
    m_pc    = RESET_PC;
    m_infl  = 1'b0;
    m_q.delete();
    cyc     = 0;
  endtask

  task automatic drive(input bit g, input bit r, input bit rv, input logic [7:0] rp,
                       input bit h);
    imem_gnt       = g;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt           = h;
  endtask

  // One clock: check outputs against the reference at negedge, then advance the reference
  task automatic cycle();
    bit         exp_req, exp_valid;
    int         occ, nstate;
    logic [7:0] hpc, hdata;
    @(negedge clk);
    occ       = m_q.size() + int'(m_infl);
    exp_req   = (m_state == 1) && !halt && !redirect_valid && (occ < int'(DEPTH));
    exp_valid = (m_q.size() != 0);
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
    end
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
    end
    checks++;
    if (instr_valid !== exp_valid) begin
      errors++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_valid);
    end
    checks++;
    if (halted !== (m_state == 2)) begin
      errors++;
      $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, m_state == 2);
    end
    checks++;
    if (imem_req === 1'b1 && occ >= int'(DEPTH)) begin
      errors++;
      $display("FAIL overflow cyc=%0d req with occupancy=%0d", cyc, occ);
    end
    if (exp_valid) begin
      hpc   = m_q[0][15:8];
      hdata = m_q[0][7:0];
      checks++;
      if (instr_pc !== hpc || instr_data !== hdata) begin
        errors++;
        $display("FAIL head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, instr_pc, instr_data, hpc, hdata);
      end
    end
    o_cyc = cyc; o_req = imem_req; o_gnt = imem_req & imem_gnt; o_addr = imem_addr;
    o_valid = instr_valid; o_pop = instr_valid & instr_ready; o_pc = instr_pc;
    o_data = instr_data; o_halted = halted;
    nstate = m_state;
    case (m_state)
      0: nstate = 1;
      1: if (halt && !m_infl) nstate = 2;
      2: if (!halt) nstate = 1;
      default: nstate = 0;
    endcase
    if (redirect_valid) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_infl = 1'b0;
    end else begin
      if (exp_valid && instr_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back({m_ipc, m_ipc ^ 8'hA5});
      if (exp_req && imem_gnt) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 8'd1;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    m_state = nstate;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got req/valid/halted=%b exp=000", {imem_req, instr_valid, halted});
    end
    checks++;
    if (imem_addr !== RESET_PC || instr_data !== 8'h00 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h pc=%h exp %h/00/00",
               imem_addr, instr_data, instr_pc, RESET_PC);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    int         first_req = -1, first_valid = -1, npop = 0;
    logic [7:0] first_data = 8'h00, exp_pc = 8'h00;
    drive(1, 1, 0, 8'h00, 0);
    repeat (12) begin
      cycle();
      if (o_req && first_req < 0) first_req = o_cyc;
      if (o_valid && first_valid < 0) begin
        first_valid = o_cyc;
        first_data  = o_data;
      end
      if (o_pop) begin
        checks++;
        if (o_pc !== exp_pc) begin
          errors++;
          $display("FAIL stream_pc got=%h exp=%h", o_pc, exp_pc);
        end
        exp_pc = exp_pc + 8'd1;
        npop++;
      end
    end
    checks++;
    if (first_req != 1 || first_valid != 3 || first_data !== 8'hA5) begin
      errors++;
      $display("FAIL stream_timing got req@%0d valid@%0d data=%h exp req@1 valid@3 data=a5",
               first_req, first_valid, first_data);
    end
    checks++;
    if (npop != 9) begin
      errors++;
      $display("FAIL stream_rate got pops=%0d exp=9", npop);
    end
  endtask

  task automatic test_backpressure();
    int         g = 0;
    logic [7:0] ga = 8'h00;
    logic [7:0] exp_pcs [4];
    int         k = 0;
    exp_pcs = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive(1, 0, 1, 8'h00, 0);
    cycle();
    drive(1, 0, 0, 8'h00, 0);
    repeat (8) begin
      cycle();
      if (o_gnt) g++;
    end
    checks++;
    if (g != 4 || o_req !== 1'b0 || o_pc !== 8'h00) begin
      errors++;
      $display("FAIL bp_fill got grants=%0d req=%b head=%h exp 4/0/00", g, o_req, o_pc);
    end
    drive(1, 1, 0, 8'h00, 0);
    cycle();
    drive(1, 0, 0, 8'h00, 0);
    g = 0;
    repeat (5) begin
      cycle();
      if (o_gnt) begin
        g++;
        ga = o_addr;
      end
    end
    checks++;
    if (g != 1 || ga !== 8'h04) begin
      errors++;
      $display("FAIL bp_resume got grants=%0d addr=%h exp 1 at 04", g, ga);
    end
    drive(0, 1, 0, 8'h00, 0);
    repeat (6) begin
      cycle();
      if (o_pop && k < 4) begin
        checks++;
        if (o_pc !== exp_pcs[k]) begin
          errors++;
          $display("FAIL bp_drain got=%h exp=%h", o_pc, exp_pcs[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL bp_drain_count got=%0d exp=4", k);
    end
  endtask

  task automatic test_grant_stall();
    drive(0, 1, 0, 8'h00, 0);
    repeat (5) begin
      cycle();
      checks++;
      if (o_req !== 1'b1 || o_addr !== 8'h05 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall got req=%b addr=%h valid=%b exp 1/05/0", o_req, o_addr, o_valid);
      end
    end
  endtask

  task automatic test_redirect();
    drive(1, 1, 1, 8'h00, 0);
    cycle();
    drive(1, 1, 0, 8'h00, 0);
    repeat (6) cycle();
    checks++;
    if (!o_gnt || o_addr !== 8'h05) begin
      errors++;
      $display("FAIL redir_setup got gnt=%b addr=%h exp grant at 05", o_gnt, o_addr);
    end
    drive(1, 1, 1, 8'h40, 0);
    cycle();
    drive(1, 1, 0, 8'h00, 0);
    cycle();
    checks++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 8'h40) begin
      errors++;
      $display("FAIL redir_r1 got valid=%b req=%b addr=%h exp 0/1/40", o_valid, o_req, o_addr);
    end
    cycle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_r2 got valid=%b exp=0", o_valid);
    end
    cycle();
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 8'h40 || o_data !== 8'hE5) begin
      errors++;
      $display("FAIL redir_r3 got valid=%b pc=%h data=%h exp 1/40/e5", o_valid, o_pc, o_data);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pcs [4];
    int         k = 0;
    exp_pcs = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    drive(1, 1, 1, 8'hFE, 0);
    cycle();
    drive(1, 1, 0, 8'h00, 0);
    repeat (8) begin
      cycle();
      if (o_pop && k < 4) begin
        checks++;
        if (o_pc !== exp_pcs[k]) begin
          errors++;
          $display("FAIL wrap_pc got=%h exp=%h", o_pc, exp_pcs[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=4", k);
    end
  endtask

  task automatic test_halt();
    drive(1, 0, 1, 8'h10, 0);
    cycle();
    drive(1, 0, 0, 8'h00, 0);
    cycle();
    checks++;
    if (!o_gnt || o_addr !== 8'h10) begin
      errors++;
      $display("FAIL halt_setup got gnt=%b addr=%h exp grant at 10", o_gnt, o_addr);
    end
    drive(1, 0, 0, 8'h00, 1);
    cycle();
    checks++;
    if (o_req !== 1'b0 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_h0 got req=%b halted=%b exp 0/0", o_req, o_halted);
    end
    cycle();
    cycle();
    checks++;
    if (o_halted !== 1'b1 || o_valid !== 1'b1 || o_pc !== 8'h10) begin
      errors++;
      $display("FAIL halt_h2 got halted=%b valid=%b pc=%h exp 1/1/10", o_halted, o_valid, o_pc);
    end
    drive(1, 1, 0, 8'h00, 1);
    cycle();
    cycle();
    checks++;
    if (o_valid !== 1'b0 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_drain got valid=%b req=%b exp 0/0", o_valid, o_req);
    end
    drive(1, 1, 0, 8'h00, 0);
    cycle();
    cycle();
    checks++;
    if (o_req !== 1'b1 || o_addr !== 8'h11 || o_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume got req=%b addr=%h halted=%b exp 1/11/0",
               o_req, o_addr, o_halted);
    end
  endtask

  task automatic test_async_reset();
    int first_req = -1;
    drive(1, 1, 0, 8'h00, 0);
    repeat (4) cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000 || imem_addr !== RESET_PC ||
        instr_data !== 8'h00 || instr_pc !== 8'h00) begin
      errors++;
      $display("FAIL async_rst got req=%b valid=%b halted=%b addr=%h data=%h pc=%h exp zeros",
               imem_req, instr_valid, halted, imem_addr, instr_data, instr_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (4) begin
      cycle();
      if (o_req && first_req < 0) begin
        first_req = o_cyc;
        checks++;
        if (o_addr !== RESET_PC) begin
          errors++;
          $display("FAIL async_restart_addr got=%h exp=%h", o_addr, RESET_PC);
        end
      end
    end
    checks++;
    if (first_req != 1) begin
      errors++;
      $display("FAIL async_restart_cycle got=%0d exp=1", first_req);
    end
  endtask

  task automatic test_random();
    bit h = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) h = ~h;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
            8'($urandom), h);
      cycle();
    end
    drive(1, 1, 0, 8'h00, 0);
    repeat (10) cycle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_grant_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
